// File: rtl/mem_fill_if.sv
// Request / memory / cache-fill bundle of the memory fill arbiter.
// slave: the arbiter side. master: requesters, memory and caches.
interface mem_fill_if #(
  parameter int WORDS_PER_BLK = 8,
  parameter int ADDR_W        = 16
);
  localparam int CW = $clog2(WORDS_PER_BLK);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [15:0]       d_wdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_valid;
  logic [15:0]       fill_data;
  logic [CW-1:0]     fill_word;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_done;
  logic              d_done;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
           i_fill_we, d_fill_we, i_done, d_done, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
           i_fill_we, d_fill_we, i_done, d_done, busy
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbiter sharing one pipelined main memory between I-side and D-side miss
// handlers: block fills (one word address per cycle, returns steered to the
// owning cache) and single-cycle D-side write-through stores.
// Optional build macro ROUND_ROBIN_EN: ties alternate between sides instead
// of D-side always winning.
module mem_fill_arbiter #(
  parameter int WORDS_PER_BLK = 8,
  parameter int ADDR_W        = 16
) (
  input logic        clk,
  input logic        rst,
  mem_fill_if.slave  bus
);
  localparam int CW = $clog2(WORDS_PER_BLK);
  localparam logic [CW-1:0]     LAST_WORD = CW'(WORDS_PER_BLK - 1);
  // clears the byte offset within the block (word offset plus byte bit)
  localparam logic [ADDR_W-1:0] BLK_MASK  = {ADDR_W{1'b1}} << (CW + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic              owner;      // 1 = D-side, 0 = I-side
  logic [ADDR_W-1:0] addr_q;     // block base for fills, raw address for stores
  logic [15:0]       wdata_q;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     recv_cnt;
  logic              grant_d;
  logic              grant_i;
  logic              rtn;
  logic              last_rtn;

`ifdef ROUND_ROBIN_EN
  logic              last_grant; // 1 = D-side granted most recently

  // tie goes to the side not granted last
  always_comb begin
    grant_d = bus.d_req & (~bus.i_req | ~last_grant);
    grant_i = bus.i_req & ~grant_d;
  end

  // remember the most recent winner, contested or not
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b0;
    else if (state == S_IDLE && (grant_d || grant_i))
      last_grant <= grant_d;
  end
`else
  // fixed priority: D-side beats I-side
  always_comb begin
    grant_d = bus.d_req;
    grant_i = bus.i_req & ~bus.d_req;
  end
`endif

  // a return only counts while a fill is outstanding; stale or surplus
  // valids in IDLE/WRITE/DONE never reach a cache
  assign rtn      = bus.mem_valid && (state == S_ISSUE || state == S_DRAIN);
  assign last_rtn = rtn && (recv_cnt == LAST_WORD);

  // grant, issue/return counting and state sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      if (rtn) recv_cnt <= recv_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
          if (grant_d) begin
            owner   <= 1'b1;
            addr_q  <= bus.d_wr ? bus.d_addr : (bus.d_addr & BLK_MASK);
            wdata_q <= bus.d_wdata;
            state   <= bus.d_wr ? S_WRITE : S_ISSUE;
          end else if (grant_i) begin
            owner  <= 1'b0;
            addr_q <= bus.i_addr & BLK_MASK;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          issue_cnt <= issue_cnt + 1'b1;
          // zero-latency memory can deliver the final word while still issuing
          if (last_rtn)                    state <= S_DONE;
          else if (issue_cnt == LAST_WORD) state <= S_DRAIN;
        end
        S_DRAIN: if (last_rtn) state <= S_DONE;
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_en    = (state == S_ISSUE) || (state == S_WRITE);
  assign bus.mem_wr    = (state == S_WRITE);
  // issue_cnt is zero in WRITE, so a store goes out at its latched address
  assign bus.mem_addr  = addr_q + ADDR_W'({issue_cnt, 1'b0});
  assign bus.mem_wdata = wdata_q;
  assign bus.fill_data = bus.mem_rdata;
  assign bus.fill_word = recv_cnt;
  assign bus.i_fill_we = rtn & ~owner;
  assign bus.d_fill_we = rtn & owner;
  assign bus.i_done    = (state == S_DONE) & ~owner;
  assign bus.d_done    = (state == S_DONE) & owner;
  assign bus.busy      = (state != S_IDLE);
endmodule
